// File: rtl/color_centroid_tracker.sv
// Colour-window pixel classifier with a serial per-colour centroid engine.
// Frame sums are snapshotted on frame_end and divided one colour at a time.
module color_centroid_tracker #(
  parameter int X_W       = 10,
  parameter int COUNT_W   = 19,
  parameter int MIN_COUNT = 16
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [59:0]    green_thr,
  input  logic [59:0]    orange_thr,
  input  logic [59:0]    pink_thr,
  input  logic [59:0]    blue_thr,
  input  logic           pix_valid,
  input  logic [9:0]     pix_lum,
  input  logic [9:0]     pix_cr,
  input  logic [9:0]     pix_cb,
  input  logic [X_W-1:0] pix_x,
  input  logic [X_W-1:0] pix_row,
  input  logic           frame_end,
  output logic           hit_valid,
  output logic [3:0]     hit,
  output logic           cent_valid,
  output logic [1:0]     cent_color,
  output logic           cent_found,
  output logic [X_W-1:0] cent_x,
  output logic [X_W-1:0] cent_y,
  output logic           busy,
  output logic           frame_dropped
);
  localparam int SUM_W = COUNT_W + X_W;
  localparam int IDX_W = $clog2(X_W);
  // MIN fields all ones, MAX fields zero: no pixel can match before the first frame_end
  localparam logic [59:0] THR_RST = {3{10'h000, 10'h3FF}};

  typedef enum logic [2:0] {IDLE, LOAD, DIV_X, DIV_Y, EMIT} state_t;
  state_t state, state_nxt;

  logic [59:0]        thr_bus [4];
  logic [59:0]        thr     [4];
  logic [X_W-1:0]     x_d, row_d;
  logic [COUNT_W-1:0] acc_cnt [4], inc_cnt [4], hold_cnt [4];
  logic [SUM_W-1:0]   acc_sx [4], inc_sx [4], hold_sx [4];
  logic [SUM_W-1:0]   acc_sy [4], inc_sy [4], hold_sy [4];
  logic [1:0]         color;
  logic [IDX_W-1:0]   bit_idx;
  logic [SUM_W-1:0]   rem, dsr, dsr_init;
  logic [X_W-1:0]     quo, quo_nxt, qx;
  logic               q_bit, found;

  assign thr_bus[0] = green_thr;
  assign thr_bus[1] = orange_thr;
  assign thr_bus[2] = pink_thr;
  assign thr_bus[3] = blue_thr;

  function automatic logic in_win(input logic [59:0] t, input logic [9:0] y,
                                  input logic [9:0] cr, input logic [9:0] cb);
    return (y  >= t[49:40]) && (y  <= t[59:50]) &&
           (cr >= t[29:20]) && (cr <= t[39:30]) &&
           (cb >= t[9:0])   && (cb <= t[19:10]);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_valid <= 1'b0;
      hit       <= '0;
      x_d       <= '0;
      row_d     <= '0;
      for (int c = 0; c < 4; c++) thr[c] <= THR_RST;
    end else begin
      hit_valid <= pix_valid;
      x_d       <= pix_x;
      row_d     <= pix_row;
      for (int c = 0; c < 4; c++) begin
        hit[c] <= pix_valid && in_win(thr[c], pix_lum, pix_cr, pix_cb);
        if (frame_end) thr[c] <= thr_bus[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      inc_cnt[c] = acc_cnt[c];
      inc_sx[c]  = acc_sx[c];
      inc_sy[c]  = acc_sy[c];
      if (hit_valid && hit[c]) begin
        if (acc_cnt[c] != '1) inc_cnt[c] = acc_cnt[c] + COUNT_W'(1);
        inc_sx[c] = acc_sx[c] + SUM_W'(x_d);
        inc_sy[c] = acc_sy[c] + SUM_W'(row_d);
      end
    end
  end

  // The snapshot takes the incremented values so a hit coinciding with frame_end is kept
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 4; c++) begin
        acc_cnt[c]  <= '0;
        acc_sx[c]   <= '0;
        acc_sy[c]   <= '0;
        hold_cnt[c] <= '0;
        hold_sx[c]  <= '0;
        hold_sy[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (frame_end) begin
          acc_cnt[c] <= '0;
          acc_sx[c]  <= '0;
          acc_sy[c]  <= '0;
          if (state == IDLE) begin
            hold_cnt[c] <= inc_cnt[c];
            hold_sx[c]  <= inc_sx[c];
            hold_sy[c]  <= inc_sy[c];
          end
        end else begin
          acc_cnt[c] <= inc_cnt[c];
          acc_sx[c]  <= inc_sx[c];
          acc_sy[c]  <= inc_sy[c];
        end
      end
    end
  end

  assign found    = hold_cnt[color] >= COUNT_W'(MIN_COUNT);
  assign dsr_init = SUM_W'(hold_cnt[color]) << (X_W - 1);
  assign q_bit    = rem >= dsr;
  assign quo_nxt  = {quo[X_W-2:0], q_bit};
  assign busy     = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_end) state_nxt = LOAD;
      LOAD:    state_nxt = found ? DIV_X : EMIT;
      DIV_X:   if (bit_idx == '0) state_nxt = DIV_Y;
      DIV_Y:   if (bit_idx == '0) state_nxt = EMIT;
      EMIT:    state_nxt = (color == 2'd3) ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Restoring divider: the divisor starts at count << (X_W-1), one quotient bit per cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      color         <= '0;
      bit_idx       <= '0;
      rem           <= '0;
      dsr           <= '0;
      quo           <= '0;
      qx            <= '0;
      cent_valid    <= 1'b0;
      cent_color    <= '0;
      cent_found    <= 1'b0;
      cent_x        <= '0;
      cent_y        <= '0;
      frame_dropped <= 1'b0;
    end else begin
      cent_valid    <= (state_nxt == EMIT);
      frame_dropped <= frame_end && (state != IDLE);
      case (state)
        IDLE: color <= '0;
        LOAD: begin
          rem     <= hold_sx[color];
          dsr     <= dsr_init;
          quo     <= '0;
          bit_idx <= IDX_W'(X_W - 1);
          if (!found) begin
            cent_color <= color;
            cent_found <= 1'b0;
            cent_x     <= '0;
            cent_y     <= '0;
          end
        end
        DIV_X, DIV_Y: begin
          rem     <= q_bit ? rem - dsr : rem;
          dsr     <= dsr >> 1;
          quo     <= quo_nxt;
          bit_idx <= bit_idx - 1'b1;
          if (bit_idx == '0) begin
            if (state == DIV_X) begin
              qx      <= quo_nxt;
              rem     <= hold_sy[color];
              dsr     <= dsr_init;
              bit_idx <= IDX_W'(X_W - 1);
            end else begin
              cent_color <= color;
              cent_found <= 1'b1;
              cent_x     <= qx;
              cent_y     <= quo_nxt;
            end
          end
        end
        EMIT:    color <= color + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_color_centroid_tracker.sv
// Bench for color_centroid_tracker: directed scenarios plus random frames, all checked
// against a frame-level model (window tests, per-frame totals, centroid schedule).
module tb_color_centroid_tracker;
  localparam int X_W       = 10;
  localparam int MIN_COUNT = 16;
  localparam int FOUND_CYC = 2 + 2 * X_W;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [59:0]    green_thr, orange_thr, pink_thr, blue_thr;
  logic           pix_valid = 1'b0;
  logic [9:0]     pix_lum = '0, pix_cr = '0, pix_cb = '0;
  logic [X_W-1:0] pix_x = '0, pix_row = '0;
  logic           frame_end = 1'b0;
  logic           hit_valid;
  logic [3:0]     hit;
  logic           cent_valid;
  logic [1:0]     cent_color;
  logic           cent_found;
  logic [X_W-1:0] cent_x, cent_y;
  logic           busy, frame_dropped;

  color_centroid_tracker #(.X_W(X_W), .COUNT_W(19), .MIN_COUNT(MIN_COUNT)) dut (
    .clock(clock), .reset_n(reset_n),
    .green_thr(green_thr), .orange_thr(orange_thr), .pink_thr(pink_thr), .blue_thr(blue_thr),
    .pix_valid(pix_valid), .pix_lum(pix_lum), .pix_cr(pix_cr), .pix_cb(pix_cb),
    .pix_x(pix_x), .pix_row(pix_row), .frame_end(frame_end),
    .hit_valid(hit_valid), .hit(hit), .cent_valid(cent_valid), .cent_color(cent_color),
    .cent_found(cent_found), .cent_x(cent_x), .cent_y(cent_y),
    .busy(busy), .frame_dropped(frame_dropped)
  );

  always #5 clock = ~clock;

  typedef struct {int color; int found; int x; int y; int cyc;} cent_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_lo [4][3], t_hi [4][3];     // limits on the buses (channel 0 Y, 1 Cr, 2 Cb)
  int m_lo [4][3], m_hi [4][3];     // limits the model holds as shadows
  longint tot_cnt [4], tot_sx [4], tot_sy [4];
  logic [3:0] pend_hit;
  int pend_x, pend_y;
  int busy_start, busy_last;
  int fe_edge;
  cent_t exp_q[$], obs_q[$], last[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    if (cent_valid === 1'b1)
      obs_q.push_back('{int'(cent_color), int'(cent_found), int'(cent_x), int'(cent_y), cyc});
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_win(input int c, input int ylo, input int yhi, input int crlo,
                         input int crhi, input int cblo, input int cbhi);
    logic [59:0] v;
    t_lo[c][0] = ylo;  t_hi[c][0] = yhi;
    t_lo[c][1] = crlo; t_hi[c][1] = crhi;
    t_lo[c][2] = cblo; t_hi[c][2] = cbhi;
    v = {10'(yhi), 10'(ylo), 10'(crhi), 10'(crlo), 10'(cbhi), 10'(cblo)};
    case (c)
      0:       green_thr  = v;
      1:       orange_thr = v;
      2:       pink_thr   = v;
      default: blue_thr   = v;
    endcase
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      for (int ch = 0; ch < 3; ch++) begin
        m_lo[c][ch] = 1023;
        m_hi[c][ch] = 0;
      end
      tot_cnt[c] = 0; tot_sx[c] = 0; tot_sy[c] = 0;
    end
    pend_hit = '0; pend_x = 0; pend_y = 0;
    busy_start = -1000; busy_last = -1000;
  endtask

  function automatic bit inside_win(input int c, input int y, input int cr, input int cb);
    return y  >= m_lo[c][0] && y  <= m_hi[c][0] &&
           cr >= m_lo[c][1] && cr <= m_hi[c][1] &&
           cb >= m_lo[c][2] && cb <= m_hi[c][2];
  endfunction

  task automatic step(input bit v, input int y, input int cr, input int cb,
                      input int px, input int prow, input bit fe);
    logic [3:0] eh;
    bit drop, bsy, fnd;
    int e, t;
    pix_valid = v; pix_lum = 10'(y); pix_cr = 10'(cr); pix_cb = 10'(cb);
    pix_x = X_W'(px); pix_row = X_W'(prow); frame_end = fe;
    for (int c = 0; c < 4; c++) eh[c] = v && inside_win(c, y, cr, cb);
    @(posedge clock); #1;
    e = cyc;
    for (int c = 0; c < 4; c++)
      if (pend_hit[c]) begin
        tot_cnt[c]++; tot_sx[c] += pend_x; tot_sy[c] += pend_y;
      end
    drop = 1'b0;
    if (fe) begin
      drop = (e - 1 >= busy_start) && (e - 1 <= busy_last);
      if (!drop) begin
        busy_start = e;
        t = e;
        for (int c = 0; c < 4; c++) begin
          fnd = tot_cnt[c] >= MIN_COUNT;
          t += fnd ? FOUND_CYC - 1 : 1;
          exp_q.push_back('{c, int'(fnd), fnd ? int'(tot_sx[c] / tot_cnt[c]) : 0,
                            fnd ? int'(tot_sy[c] / tot_cnt[c]) : 0, t});
          t++;
        end
        busy_last = t - 1;
      end
      for (int c = 0; c < 4; c++) begin
        tot_cnt[c] = 0; tot_sx[c] = 0; tot_sy[c] = 0;
        for (int ch = 0; ch < 3; ch++) begin
          m_lo[c][ch] = t_lo[c][ch];
          m_hi[c][ch] = t_hi[c][ch];
        end
      end
    end
    bsy = (e >= busy_start) && (e <= busy_last);
    pix_valid = 1'b0; frame_end = 1'b0;
    check_val("hit_valid", hit_valid, v);
    check_val("hit", hit, eh);
    check_val("frame_dropped", frame_dropped, drop);
    check_val("busy", busy, bsy);
    pend_hit = eh; pend_x = px; pend_y = prow;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic frame();
    step(0, 0, 0, 0, 0, 0, 1);
    fe_edge = cyc;
  endtask

  task automatic drain(input string tag);
    int n;
    cent_t ex, ob;
    n = busy_last - cyc + 2;
    if (n < 2) n = 2;
    if (n > 400) n = 400;
    for (int i = 0; i < n; i++) idle();
    check_val({tag, "_nstrobe"}, obs_q.size(), exp_q.size());
    last = obs_q;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ex = exp_q.pop_front();
      ob = obs_q.pop_front();
      check_val({tag, "_color"}, ob.color, ex.color);
      check_val({tag, "_found"}, ob.found, ex.found);
      check_val({tag, "_x"},     ob.x,     ex.x);
      check_val({tag, "_y"},     ob.y,     ex.y);
      check_val({tag, "_cyc"},   ob.cyc,   ex.cyc);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  function automatic cent_t get_last(input int k);
    cent_t r = '{-1, -1, -1, -1, -1};
    if (k < last.size()) r = last[k];
    return r;
  endfunction

  task automatic green_hits(input int n, input int px, input int prow);
    for (int i = 0; i < n; i++) step(1, 150, 512, 512, px, prow, 0);
  endtask

  initial begin
    cent_t r;
    int k, c, y, cr, cb;
    for (int i = 0; i < 4; i++) set_win(i, 1023, 0, 1023, 0, 1023, 0);
    model_reset();

    @(posedge clock); #1;
    check_val("rst_hit", {hit_valid, hit}, 0);
    check_val("rst_cent", {cent_valid, cent_color, cent_found, cent_x, cent_y}, 0);
    check_val("rst_busy", {busy, frame_dropped}, 0);
    @(posedge clock);
    @(negedge clock) reset_n = 1'b1;

    // window boundaries
    set_win(0, 100, 200, 0, 1023, 0, 1023);
    step(1, 100, 5, 5, 3, 4, 0);
    check_val("pre_frame_hit", hit, 0);
    frame();
    step(1, 100, 5, 5, 3, 4, 0);  check_val("bnd_y100", hit[0], 1);
    step(1, 200, 5, 5, 3, 4, 0);  check_val("bnd_y200", hit[0], 1);
    step(1, 201, 5, 5, 3, 4, 0);  check_val("bnd_y201", hit[0], 0);
    step(1, 99, 1023, 0, 3, 4, 0); check_val("bnd_y99", hit[0], 0);
    drain("t1");

    // basic centroid
    frame(); drain("t2a");
    for (int i = 0; i < 20; i++) step(1, 150, 512, 512, 10 + i, 50, 0);
    frame(); k = fe_edge; drain("t2");
    r = get_last(0);
    check_val("cen_found", r.found, 1);
    check_val("cen_x", r.x, 19);
    check_val("cen_y", r.y, 50);
    check_val("cen_lat", r.cyc - k, FOUND_CYC - 1);
    r = get_last(3);
    check_val("cen_blue_found", r.found, 0);
    check_val("cen_blue_x", r.x, 0);
    check_val("cen_blue_lat", r.cyc - k, FOUND_CYC - 1 + 6);

    // MIN_COUNT threshold on orange
    set_win(1, 300, 400, 600, 700, 10, 20);
    frame(); drain("t3a");
    for (int i = 0; i < 15; i++) step(1, 350, 650, 15, 200 + i, 9, 0);
    frame(); drain("t3b");
    r = get_last(1);
    check_val("thr15_found", r.found, 0);
    check_val("thr15_x", r.x, 0);
    for (int i = 0; i < 16; i++) step(1, 350, 650, 15, 100, 7, 0);
    frame(); drain("t3c");
    r = get_last(1);
    check_val("thr16_found", r.found, 1);
    check_val("thr16_x", r.x, 100);
    check_val("thr16_y", r.y, 7);

    // overrun
    for (int i = 0; i < 20; i++) step(1, 150, 512, 512, 10 + i, 50, 0);
    frame();
    green_hits(3, 900, 400);
    repeat (6) idle();
    frame();
    check_val("ovr_drop", frame_dropped, 1);
    idle();
    check_val("ovr_drop_end", frame_dropped, 0);
    green_hits(17, 500, 300);
    drain("t4a");
    frame(); drain("t4b");
    r = get_last(0);
    check_val("ovr_next_x", r.x, 500);
    check_val("ovr_next_y", r.y, 300);

    // hit coinciding with frame_end
    green_hits(16, 600, 20);
    frame(); drain("t5a");
    r = get_last(0);
    check_val("coin_found", r.found, 1);
    check_val("coin_x", r.x, 600);
    frame(); drain("t5b");
    r = get_last(0);
    check_val("coin_next_found", r.found, 0);

    // asynchronous reset in the middle of DIV_Y
    green_hits(20, 200, 100);
    frame();
    k = fe_edge;
    repeat (14) idle();
    green_hits(1, 1, 1);
    #2 reset_n = 1'b0;
    #1;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_cv", cent_valid, 0);
    check_val("mid_rst_hit", hit, 0);
    model_reset();
    while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc > cyc) void'(exp_q.pop_back());
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    repeat (30) idle();
    check_val("mid_rst_nostrobe", obs_q.size(), 0);
    drain("t6a");
    frame(); drain("t6b");
    green_hits(18, 300, 200);
    frame(); drain("t6c");
    r = get_last(0);
    check_val("post_rst_x", r.x, 300);
    check_val("post_rst_y", r.y, 200);

    // random frames
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 4; i++) begin
        int a, b, d;
        a = $urandom_range(0, 700); b = $urandom_range(0, 700); d = $urandom_range(0, 700);
        set_win(i, a, a + $urandom_range(50, 323), b, b + $urandom_range(50, 323),
                d, d + $urandom_range(50, 323));
      end
      frame();
      for (int p = 0; p < int'($urandom_range(60, 160)); p++) begin
        c = $urandom_range(0, 4);
        if (c < 4) begin
          y  = $urandom_range(m_lo[c][0], m_hi[c][0]);
          cr = $urandom_range(m_lo[c][1], m_hi[c][1]);
          cb = $urandom_range(m_lo[c][2], m_hi[c][2]);
        end else begin
          y = $urandom_range(0, 1023); cr = $urandom_range(0, 1023); cb = $urandom_range(0, 1023);
        end
        step($urandom_range(0, 9) != 0, y, cr, cb, $urandom_range(0, 639),
             $urandom_range(0, 479), $urandom_range(0, 59) == 0);
      end
      drain("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
